// File: rtl/cp_intr_pkg.sv
// ============================================================================
//  cp_intr_pkg
//  Shared constants for the crypto-processor interrupt controller:
//  register byte offsets and COAL_CFG field positions.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package cp_intr_pkg;

    // Register byte offsets (word aligned)
    localparam int OFS_ENABLE  = 'h00;
    localparam int OFS_PENDING = 'h04;
    localparam int OFS_GLOBAL  = 'h08;
    localparam int OFS_RAW     = 'h0C;
    localparam int OFS_EDGE    = 'h10;
    localparam int OFS_SWSET   = 'h14;
    localparam int OFS_COAL    = 'h18;

    // COAL_CFG field positions
    localparam int COAL_THRESH_LSB = 0;
    localparam int COAL_THRESH_MSB = 7;
    localparam int COAL_TMO_LSB    = 16;
    localparam int COAL_TMO_MSB    = 31;

    // Writable bits of COAL_CFG and its reset value (THRESH = 1, TIMEOUT = 0)
    localparam logic [31:0] COAL_WR_MASK = 32'hFFFF_00FF;
    localparam logic [31:0] COAL_RST     = 32'h0000_0001;

endpackage

`default_nettype wire

// File: rtl/cp_intr_ctrl_if.sv
// ============================================================================
//  cp_intr_ctrl_if
//  APB slave bus bundle for the interrupt controller. The block select is
//  already decoded by the top, so only the low address bits matter here.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp_intr_ctrl_if;

    logic        iPsel;
    logic        iPenable;
    logic        iPwrite;
    logic [15:0] iPaddr;
    logic [31:0] iPwdata;
    logic [31:0] oPrdata;

    modport master (
        output iPsel, iPenable, iPwrite, iPaddr, iPwdata,
        input  oPrdata
    );

    modport slave (
        input  iPsel, iPenable, iPwrite, iPaddr, iPwdata,
        output oPrdata
    );

endinterface

`default_nettype wire

// File: rtl/cp_intr_ctrl_coalesce.sv
// ============================================================================
//  cp_intr_coalesce
//  Event coalescing stage: counts new enabled events and the time spent with
//  an enabled interrupt pending, and releases the interrupt once either the
//  event threshold or the timeout is reached. Only built when
//  CP_INTR_COALESCE_EN is defined.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cp_intr_coalesce (
    input  wire logic        iClk,
    input  wire logic        iRsn,
    input  wire logic        active,    // some enabled bit is pending
    input  wire logic        new_evt,   // a new enabled bit arrives this cycle
    input  wire logic [7:0]  thresh,
    input  wire logic [15:0] timeout,
    output logic             coal_rel   // interrupt may be presented
);

    logic [7:0]  evt_cnt;
    logic [15:0] tmo_cnt;
    logic        rel_q;
    logic [7:0]  thr_eff;
    logic [7:0]  evt_base;
    logic        rel_cond;

    // A threshold of 0 would release with no events; treat it as 1.
    assign thr_eff  = (thresh == 8'd0) ? 8'd1 : thresh;
    assign rel_cond = (evt_cnt >= thr_eff) ||
                      ((timeout != 16'd0) && (tmo_cnt == timeout - 16'd1));
    assign coal_rel = rel_q | rel_cond;

    // An idle controller starts counting from zero so the arriving event counts.
    assign evt_base = active ? evt_cnt : 8'd0;

    // Counters and release flag; everything collapses once nothing enabled is pending.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            evt_cnt <= 8'd0;
            tmo_cnt <= 16'd0;
            rel_q   <= 1'b0;
        end else begin
            evt_cnt <= (new_evt && evt_base != 8'hFF) ? evt_base + 8'd1 : evt_base;
            rel_q   <= active & (rel_q | rel_cond);
            if (!active)
                tmo_cnt <= 16'd0;
            else if (!coal_rel)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cp_intr_ctrl.sv
// ============================================================================
//  cp_intr_ctrl
//  APB interrupt controller: per-source enable, edge/level mode, sticky W1C
//  pending and W1S software set, a global enable, and one registered
//  interrupt output. Optional coalescing under macro CP_INTR_COALESCE_EN.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cp_intr_ctrl
    import cp_intr_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int ADDR_W        = 8,
    parameter int RST_EDGE_MODE = 0
) (
    input  wire logic               iClk,
    input  wire logic               iRsn,
    cp_intr_ctrl_if.slave           apb,
    input  wire logic [NUM_SRC-1:0] iIntSrc,
    output logic                    oInt
);

    localparam logic [NUM_SRC-1:0] EDGE_RST = (RST_EDGE_MODE != 0) ? {NUM_SRC{1'b1}} : '0;

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] src_d;
    logic               global_en;

    logic [ADDR_W-1:0]  ofs;
    logic               wr_en;
    logic               rd_setup;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] swset_mask;
    logic               active;
    logic               irq_gate;
    logic [31:0]        rd_mux;

    assign ofs      = {apb.iPaddr[ADDR_W-1:2], 2'b00};
    assign wr_en    = apb.iPsel &  apb.iPenable &  apb.iPwrite;
    assign rd_setup = apb.iPsel & ~apb.iPenable & ~apb.iPwrite;
    assign wdata    = apb.iPwdata[NUM_SRC-1:0];

    // Edge-mode bits only fire on a 0->1 transition; level-mode bits fire while high.
    assign set_vec    = iIntSrc & ~(edge_mode & src_d);
    assign w1c_mask   = (wr_en && ofs == ADDR_W'(OFS_PENDING)) ? wdata : '0;
    assign swset_mask = (wr_en && ofs == ADDR_W'(OFS_SWSET))   ? wdata : '0;
    assign active     = |(pending & enable);

`ifdef CP_INTR_COALESCE_EN
    logic [31:0] coal_cfg;
    logic        new_evt;
    logic        coal_rel;

    assign new_evt = |((set_vec | swset_mask) & enable & ~pending);

    // Coalescing configuration register.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)
            coal_cfg <= COAL_RST;
        else if (wr_en && ofs == ADDR_W'(OFS_COAL))
            coal_cfg <= apb.iPwdata & COAL_WR_MASK;
    end

    cp_intr_coalesce u_coalesce (
        .iClk     (iClk),
        .iRsn     (iRsn),
        .active   (active),
        .new_evt  (new_evt),
        .thresh   (coal_cfg[COAL_THRESH_MSB:COAL_THRESH_LSB]),
        .timeout  (coal_cfg[COAL_TMO_MSB:COAL_TMO_LSB]),
        .coal_rel (coal_rel)
    );

    assign irq_gate = coal_rel;
`else
    assign irq_gate = 1'b1;
`endif

    // Read data selection; unmapped offsets and SWSET read as zero.
    always_comb begin
        rd_mux = 32'd0;
        if (ofs == ADDR_W'(OFS_ENABLE))  rd_mux = 32'(enable);
        if (ofs == ADDR_W'(OFS_PENDING)) rd_mux = 32'(pending);
        if (ofs == ADDR_W'(OFS_GLOBAL))  rd_mux = {31'd0, global_en};
        if (ofs == ADDR_W'(OFS_RAW))     rd_mux = 32'(src_d);
        if (ofs == ADDR_W'(OFS_EDGE))    rd_mux = 32'(edge_mode);
`ifdef CP_INTR_COALESCE_EN
        if (ofs == ADDR_W'(OFS_COAL))    rd_mux = coal_cfg;
`endif
    end

    // Configuration registers written by APB.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            enable    <= '0;
            global_en <= 1'b0;
            edge_mode <= EDGE_RST;
        end else if (wr_en) begin
            if (ofs == ADDR_W'(OFS_ENABLE)) enable    <= wdata;
            if (ofs == ADDR_W'(OFS_GLOBAL)) global_en <= apb.iPwdata[0];
            if (ofs == ADDR_W'(OFS_EDGE))   edge_mode <= wdata;
        end
    end

    // Source sampling and sticky pending; a new set beats a simultaneous W1C.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            src_d   <= '0;
            pending <= '0;
        end else begin
            src_d   <= iIntSrc;
            pending <= (pending & ~w1c_mask) | set_vec | swset_mask;
        end
    end

    // Read data is captured in the setup phase so it is stable for the access phase.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)
            apb.oPrdata <= 32'd0;
        else if (rd_setup)
            apb.oPrdata <= rd_mux;
    end

    // Registered interrupt output.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)
            oInt <= 1'b0;
        else
            oInt <= global_en & active & irq_gate;
    end

endmodule

`default_nettype wire

// File: tb/tb_cp_intr_ctrl.sv
// ============================================================================
//  tb_cp_intr_ctrl
//  Self-checking bench for cp_intr_ctrl. Read expectations are queued when a
//  read is issued and compared when the data appears on the bus.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp_intr_ctrl;

    localparam int NUM_SRC       = 4;
    localparam int RST_EDGE_MODE = 0;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_SRC-1:0] src = '0;
    logic               irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    cp_intr_ctrl_if apb ();

    cp_intr_ctrl #(
        .NUM_SRC       (NUM_SRC),
        .ADDR_W        (8),
        .RST_EDGE_MODE (RST_EDGE_MODE)
    ) dut (
        .iClk    (clk),
        .iRsn    (rst_n),
        .apb     (apb),
        .iIntSrc (src),
        .oInt    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        apb.iPsel = 1'b1; apb.iPenable = 1'b0; apb.iPwrite = 1'b1;
        apb.iPaddr = addr; apb.iPwdata = data;
        @(negedge clk);
        apb.iPenable = 1'b1;
        @(negedge clk);
        apb.iPsel = 1'b0; apb.iPenable = 1'b0; apb.iPwrite = 1'b0;
    endtask

    task automatic apb_read(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        apb.iPsel = 1'b1; apb.iPenable = 1'b0; apb.iPwrite = 1'b0; apb.iPaddr = addr;
        @(negedge clk);
        apb.iPenable = 1'b1;
        e = exp_q.pop_front();
        check(tag, apb.oPrdata, e);
        @(negedge clk);
        apb.iPsel = 1'b0; apb.iPenable = 1'b0;
    endtask

    task automatic pulse_src(input int idx);
        @(negedge clk);
        src[idx] = 1'b1;
        @(negedge clk);
        src[idx] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rst_exp [6];
        apb.iPsel = 1'b0; apb.iPenable = 1'b0; apb.iPwrite = 1'b0;
        apb.iPaddr = '0; apb.iPwdata = '0;

        // Reset and defaults
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_oint", {31'd0, irq}, 32'd0);
        check("rst_prdata", apb.oPrdata, 32'd0);
        rst_exp = '{32'd0, 32'd0, 32'd0, 32'd0,
                    (RST_EDGE_MODE != 0) ? 32'hF : 32'd0, 32'd0};
        for (int i = 0; i < 6; i++)
            apb_read("rst_reg", 16'(i * 4), rst_exp[i]);

        // Basic flow
        apb_write(16'h00, 32'h1);
        apb_write(16'h08, 32'h1);
        @(negedge clk); src[0] = 1'b1;
        @(negedge clk); src[0] = 1'b0;
        check("basic_oint_lat1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("basic_oint_lat2", {31'd0, irq}, 32'd1);
        apb_read("basic_pend", 16'h04, 32'h1);
        apb_write(16'h04, 32'h1);
        check("basic_oint_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("basic_oint_clr", {31'd0, irq}, 32'd0);
        apb_read("basic_pend_clr", 16'h04, 32'h0);

        // Register width and map edges
        apb_write(16'h00, 32'hFFFF_FFFF);
        apb_read("enable_width", 16'h00, 32'hF);
        apb_read("global_rd", 16'h08, 32'h1);
        apb_write(16'h1C, 32'hFFFF_FFFF);
        apb_read("unmapped", 16'h1C, 32'h0);
        apb_write(16'h00, 32'h1);
        apb_write(16'h02, 32'h0);   // low address bits ignored -> hits ENABLE
        apb_read("addr_lsb", 16'h00, 32'h0);
        apb_write(16'h00, 32'h1);

        // RAW reflects sampled sources
        @(negedge clk); src = 4'h5;
        @(negedge clk);
        apb_read("raw", 16'h0C, 32'h5);
        src = 4'h0;
        apb_write(16'h04, 32'hF);
        apb_read("raw_pend_clr", 16'h04, 32'h0);

        // Level vs edge
        apb_write(16'h10, 32'h0);
        @(negedge clk); src[1] = 1'b1;
        apb_write(16'h04, 32'h2);
        apb_read("level_reset", 16'h04, 32'h2);
        apb_write(16'h10, 32'h2);
        apb_write(16'h04, 32'h2);
        apb_read("edge_clear", 16'h04, 32'h0);
        apb_read("edge_mode_rd", 16'h10, 32'h2);
        src[1] = 1'b0;

        // Masking: disabled source latches but does not interrupt
        pulse_src(2);
        @(negedge clk);
        apb_read("mask_pend", 16'h04, 32'h4);
        check("mask_oint", {31'd0, irq}, 32'd0);
        apb_write(16'h04, 32'h4);

        // Set beats simultaneous W1C
        pulse_src(0);
        @(negedge clk);
        apb.iPsel = 1'b1; apb.iPenable = 1'b0; apb.iPwrite = 1'b1;
        apb.iPaddr = 16'h04; apb.iPwdata = 32'h1;
        @(negedge clk);
        apb.iPenable = 1'b1; src[0] = 1'b1;
        @(negedge clk);
        apb.iPsel = 1'b0; apb.iPenable = 1'b0; apb.iPwrite = 1'b0; src[0] = 1'b0;
        apb_read("set_wins", 16'h04, 32'h1);
        apb_write(16'h04, 32'h1);
        apb_read("set_wins_clr", 16'h04, 32'h0);

        // Software set and global gate
        apb_write(16'h00, 32'h8);
        apb_write(16'h08, 32'h0);
        apb_write(16'h14, 32'h8);
        apb_read("swset_pend", 16'h04, 32'h8);
        apb_read("swset_rd", 16'h14, 32'h0);
        check("swset_oint_gated", {31'd0, irq}, 32'd0);
        apb_write(16'h08, 32'h1);
        check("glob_oint_lat", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("glob_oint", {31'd0, irq}, 32'd1);

        // Reset in the middle of a read
        @(negedge clk);
        apb.iPsel = 1'b1; apb.iPenable = 1'b0; apb.iPwrite = 1'b0; apb.iPaddr = 16'h00;
        @(negedge clk);
        apb.iPenable = 1'b1;
        check("midrd_data", apb.oPrdata, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("midrd_rst_prdata", apb.oPrdata, 32'd0);
        check("midrd_rst_oint", {31'd0, irq}, 32'd0);
        @(negedge clk);
        apb.iPsel = 1'b0; apb.iPenable = 1'b0;
        rst_n = 1'b1;
        apb_read("post_rst_pend", 16'h04, 32'h0);
        apb_read("post_rst_en", 16'h00, 32'h0);

`ifdef CP_INTR_COALESCE_EN
        apb_read("coal_rst", 16'h18, 32'h1);
        apb_write(16'h00, 32'h7);
        apb_write(16'h08, 32'h1);
        apb_write(16'h10, 32'h7);
        apb_write(16'h18, 32'h0000_0003);
        pulse_src(0);
        repeat (3) @(negedge clk);
        check("coal_thr_1", {31'd0, irq}, 32'd0);
        pulse_src(1);
        repeat (3) @(negedge clk);
        check("coal_thr_2", {31'd0, irq}, 32'd0);
        pulse_src(2);
        check("coal_thr_3_lat", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("coal_thr_3", {31'd0, irq}, 32'd1);
        apb_write(16'h04, 32'h7);
        @(negedge clk);
        check("coal_clr", {31'd0, irq}, 32'd0);
        apb_write(16'h18, 32'h0014_0008);
        apb_read("coal_cfg_rd", 16'h18, 32'h0014_0008);
        pulse_src(0);
        repeat (19) @(negedge clk);
        check("coal_tmo_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("coal_tmo", {31'd0, irq}, 32'd1);
`else
        apb_write(16'h18, 32'hFFFF_FFFF);
        apb_read("coal_absent", 16'h18, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cp_intr_ctrl.md
Name: cp_intr_ctrl

Overview:
- Parametrised APB interrupt controller for the crypto-processor top. Next generation of the single-source enable/pending/global-enable scheme at 0xA000/0xA004/0xA008.
- Aggregates NUM_SRC sources (AES done, DMA done, error, etc.). Each source has its own enable, edge/level mode, sticky pending (W1C) and software set.
- Drives one registered oInt to the host. An optional coalescing stage batches events.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..32); bit i of every register maps to source i.
- ADDR_W, 8, number of low iPaddr bits decoded; upper address bits are decoded by the top.
- RST_EDGE_MODE, 0, reset value of EDGE_MODE register bits (0 = level, 1 = rising edge).

Ports:
- iClk  in  1  system clock
- iRsn  in  1  reset, asynchronous, active-low
- iPsel  in  1  APB select, block already decoded by the top
- iPenable  in  1  APB access phase
- iPwrite  in  1  APB write (1) / read (0)
- iPaddr  in  16  APB address; only [ADDR_W-1:0] is used
- iPwdata  in  32  APB write data
- oPrdata  out  32  APB read data, registered
- iIntSrc  in  NUM_SRC  raw interrupt sources, synchronous to iClk
- oInt  out  1  aggregated interrupt, registered, active-high

Behaviour:
- Clock and reset: one clock, iClk. iRsn is asynchronous and active-low. All flops clear on iRsn=0 at any time, including mid-transfer. A transfer in progress at reset is dropped.
- Register map (byte offsets, word aligned; iPaddr[1:0] ignored):
  - 0x00 ENABLE, RW, reset 0.
  - 0x04 PENDING. Reads return the sticky bits. Writing 1 clears that bit (W1C); writing 0 has no effect.
  - 0x08 GLOBAL_EN, RW, bit0 only, reset 0.
  - 0x0C RAW. Read-only; returns iIntSrc as sampled one cycle earlier.
  - 0x10 EDGE_MODE, RW, reset {NUM_SRC{RST_EDGE_MODE}}.
  - 0x14 SWSET. Writing 1 sets that pending bit (W1S). Reads return 0.
  - 0x18 COAL_CFG (feature only, see below).
- Bits at or above NUM_SRC read 0 and ignore writes. Unmapped offsets read 0 and ignore writes.
- APB write: commits on the clock edge where iPsel & iPenable & iPwrite. No wait states.
- APB read: oPrdata is loaded on the setup-phase edge (iPsel & ~iPenable & ~iPwrite). It is therefore stable throughout the access phase, and the host samples it at the end of the access phase.
  - oPrdata holds its value otherwise; reset value 0.
- Source detection: src_d is a 1-cycle registered copy of iIntSrc, reset 0.
  - Edge mode: set_i = iIntSrc[i] & ~src_d[i].
  - Level mode: set_i = iIntSrc[i]. A W1C while the source is still high re-sets the bit on the next cycle.
- Pending update each cycle:
  - PENDING <= (PENDING & ~w1c_mask) | set_vec | swset_mask.
  - Set wins over a simultaneous W1C on the same bit.
  - Pending latches regardless of ENABLE. ENABLE gates only oInt.
- oInt (no feature): oInt <= GLOBAL_EN & |(PENDING & ENABLE). Latency is 2 cycles from the iIntSrc rising edge to oInt.
  - oInt deasserts 1 cycle after the last enabled pending bit clears, or after GLOBAL_EN goes to 0.
- A PENDING read in the same cycle as a new set returns the pre-update value.

Optional Feature:
- Macro: CP_INTR_COALESCE_EN. When defined, it adds COAL_CFG and event coalescing.
- COAL_CFG fields:
  - [7:0] THRESH, reset 1.
  - [31:16] TIMEOUT in cycles, reset 0; 0 disables the timeout.
- Event counter: evt_cnt (8-bit, saturating) increments in each cycle where (set_vec | swset_mask) & ENABLE & ~PENDING is non-zero, i.e. at least one new enabled bit arrives.
- Timer: tmo_cnt (16-bit) runs while |(PENDING & ENABLE) and coalescing is not yet released.
- Release condition: evt_cnt >= THRESH, or (TIMEOUT != 0 and tmo_cnt == TIMEOUT-1).
- While released, oInt follows the no-feature equation.
- When |(PENDING & ENABLE) returns to 0: evt_cnt, tmo_cnt and the release flag clear.
- THRESH = 0 behaves as THRESH = 1.
- Without the macro: COAL_CFG reads 0, ignores writes, and no counter logic is instantiated.

Decomposition:
- Shared package cp_intr_pkg:
  - Register offset localparams: OFS_ENABLE, OFS_PENDING, OFS_GLOBAL, OFS_RAW, OFS_EDGE, OFS_SWSET, OFS_COAL.
  - COAL_CFG field LSB/MSB constants.
- Natural sub-module: cp_intr_coalesce. It holds evt_cnt, tmo_cnt and the release flag, and is instantiated only under CP_INTR_COALESCE_EN.
- The APB decode and pending logic stay in the top of this block.

Test Plan:
- Reset/defaults:
  - Hold iRsn=0 for 2 cycles, release, then read 0x00..0x14.
  - Expect all 0, EDGE_MODE = RST_EDGE_MODE pattern, oInt=0.
- Basic flow (matches the top-level flow):
  - Write 0x00=1, write 0x08=1, pulse iIntSrc[0] for 1 cycle.
  - Expect oInt=1 two cycles later; read 0x04 returns 0x1.
  - Write 0x04=1; expect oInt=0 one cycle later and 0x04 reads 0.
- Level vs edge:
  - Set EDGE_MODE=0, hold iIntSrc[1]=1, write 0x04=0x2: pending re-reads 0x2.
  - Set EDGE_MODE=0x2 and repeat: pending reads 0 after the W1C.
- Masking and simultaneous events:
  - With ENABLE=0x1, pulse iIntSrc[2]: expect pending 0x4 and oInt=0.
  - Issue a W1C of bit0 in the same cycle as a new edge on src0: pending bit0 stays 1.
- Software set and global gate:
  - Write 0x14=0x8 with ENABLE=0x8 and GLOBAL_EN=0: pending 0x8, oInt=0.
  - Write 0x08=1: oInt=1 on the next cycle.
  - Assert iRsn=0 mid-APB-read: oPrdata=0 and oInt=0 immediately.
- Coalescing (macro defined):
  - THRESH=3, TIMEOUT=0, edges on src0, src1 and src2 in separate cycles: oInt rises only after the third.
  - THRESH=8, TIMEOUT=20, single event: oInt rises after 20 cycles.
